// File: rtl/vta_regs_pkg.sv
// Shared definitions for the VTA host control/status register block:
// register map, CTRL bit positions, response code and the byte-strobe merge.
package vta_regs_pkg;

    localparam int NUM_REGS = 9;

    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_ECNT       = 8'h04;
    localparam logic [7:0] OFF_INSN_COUNT = 8'h08;
    localparam logic [7:0] OFF_PTR_INSN   = 8'h0C;
    localparam logic [7:0] OFF_PTR_UOP    = 8'h10;
    localparam logic [7:0] OFF_PTR_INP    = 8'h14;
    localparam logic [7:0] OFF_PTR_WGT    = 8'h18;
    localparam logic [7:0] OFF_PTR_ACC    = 8'h1C;
    localparam logic [7:0] OFF_PTR_OUT    = 8'h20;

    // Decode works on the word index, i.e. byte offset bits [7:2].
    localparam logic [5:0] WORD_CTRL       = OFF_CTRL[7:2];
    localparam logic [5:0] WORD_ECNT       = OFF_ECNT[7:2];
    localparam logic [5:0] WORD_INSN_COUNT = OFF_INSN_COUNT[7:2];
    localparam logic [5:0] WORD_PTR_INSN   = OFF_PTR_INSN[7:2];
    localparam logic [5:0] WORD_PTR_UOP    = OFF_PTR_UOP[7:2];
    localparam logic [5:0] WORD_PTR_INP    = OFF_PTR_INP[7:2];
    localparam logic [5:0] WORD_PTR_WGT    = OFF_PTR_WGT[7:2];
    localparam logic [5:0] WORD_PTR_ACC    = OFF_PTR_ACC[7:2];
    localparam logic [5:0] WORD_PTR_OUT    = OFF_PTR_OUT[7:2];

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_VALID} rd_state_t;

    function automatic logic [31:0] applyStrobe(input logic [31:0] oldVal,
                                                input logic [31:0] newVal,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[b*8 +: 8] = newVal[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave handshake: gathers AW/W beats independently, issues one
// register write strobe per transaction, and serves single-beat reads.
module axil_slave_if
    import vta_regs_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [ADDR_BITS-1:0]   s_awaddr,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic [DATA_BITS-1:0]   s_wdata,
    input  logic [DATA_BITS/8-1:0] s_wstrb,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [1:0]             s_bresp,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    input  logic [ADDR_BITS-1:0]   s_araddr,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [DATA_BITS-1:0]   s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   wr_en,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    output logic [DATA_BITS/8-1:0] wr_strb,
    output logic                   rd_en,
    output logic [ADDR_BITS-1:0]   rd_addr,
    input  logic [DATA_BITS-1:0]   rd_data
);

    wr_state_t r_wrState, w_wrNext;
    rd_state_t r_rdState, w_rdNext;

    logic                   r_awHeld;
    logic                   r_wHeld;
    logic [ADDR_BITS-1:0]   r_awAddr;
    logic [DATA_BITS-1:0]   r_wData;
    logic [DATA_BITS/8-1:0] r_wStrb;
    logic [DATA_BITS-1:0]   r_rData;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wrState <= WR_COLLECT;
            r_rdState <= RD_IDLE;
        end else begin
            r_wrState <= w_wrNext;
            r_rdState <= w_rdNext;
        end
    end

    // The write commits in the cycle where both beats are already held.
    always_comb begin
        w_wrNext  = r_wrState;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        wr_en     = 1'b0;
        case (r_wrState)
            WR_COLLECT: begin
                s_awready = !r_awHeld;
                s_wready  = !r_wHeld;
                if (r_awHeld && r_wHeld) begin
                    wr_en    = 1'b1;
                    w_wrNext = WR_RESP;
                end
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_wrNext = WR_COLLECT;
            end
            default: w_wrNext = WR_COLLECT;
        endcase
    end

    always_comb begin
        w_rdNext  = r_rdState;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        rd_en     = 1'b0;
        case (r_rdState)
            RD_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    rd_en    = 1'b1;
                    w_rdNext = RD_VALID;
                end
            end
            RD_VALID: begin
                s_rvalid = 1'b1;
                if (s_rready) w_rdNext = RD_IDLE;
            end
            default: w_rdNext = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awAddr <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
        end else if (wr_en) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
        end else begin
            if (s_awvalid && s_awready) begin
                r_awHeld <= 1'b1;
                r_awAddr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_wHeld <= 1'b1;
                r_wData <= s_wdata;
                r_wStrb <= s_wstrb;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)  r_rData <= '0;
        else if (rd_en) r_rData <= rd_data;
    end

    assign wr_addr = r_awAddr;
    assign wr_data = r_wData;
    assign wr_strb = r_wStrb;
    assign rd_addr = s_araddr;
    assign s_rdata = r_rData;
    assign s_bresp = RESP_OKAY;
    assign s_rresp = RESP_OKAY;

endmodule

// File: rtl/vta_sys_wrapper.sv
// VTA host register block: AXI-Lite slave holding CTRL, the cycle counter,
// the instruction count and DRAM pointers, driven straight to the core.
module vta_sys_wrapper
    import vta_regs_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int NUM_PTRS  = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ADDR_BITS-1:0] s_awaddr,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [DATA_BITS-1:0] s_wdata,
    input  logic [3:0]           s_wstrb,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ADDR_BITS-1:0] s_araddr,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [DATA_BITS-1:0] s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 launch,
    input  logic                 finish,
    output logic [DATA_BITS-1:0] insn_count,
    output logic [DATA_BITS-1:0] ptr_insn,
    output logic [DATA_BITS-1:0] ptr_uop,
    output logic [DATA_BITS-1:0] ptr_inp,
    output logic [DATA_BITS-1:0] ptr_wgt,
    output logic [DATA_BITS-1:0] ptr_acc,
    output logic [DATA_BITS-1:0] ptr_out
);

    logic                 w_wrEn;
    logic [ADDR_BITS-1:0] w_wrAddr;
    logic [DATA_BITS-1:0] w_wrData;
    logic [3:0]           w_wrStrb;
    logic                 w_rdEn;
    logic [ADDR_BITS-1:0] w_rdAddr;
    logic [DATA_BITS-1:0] w_rdData;
    logic [5:0]           w_wrWord;
    logic [5:0]           w_rdWord;
    logic                 w_startWrite;
    logic                 w_unused;

    logic                 r_start;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_ecnt;
    logic [DATA_BITS-1:0] r_insnCount;
    logic [DATA_BITS-1:0] r_ptr [NUM_PTRS];

    axil_slave_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_axil (
        .clock(clock), .reset_n(reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .wr_en(w_wrEn), .wr_addr(w_wrAddr), .wr_data(w_wrData), .wr_strb(w_wrStrb),
        .rd_en(w_rdEn), .rd_addr(w_rdAddr), .rd_data(w_rdData)
    );

    assign w_wrWord     = w_wrAddr[7:2];
    assign w_rdWord     = w_rdAddr[7:2];
    assign w_startWrite = w_wrEn && (w_wrWord == WORD_CTRL) && w_wrStrb[0] && w_wrData[CTRL_START];
    assign w_unused     = &{1'b0, w_wrAddr[ADDR_BITS-1:8], w_wrAddr[1:0],
                               w_rdAddr[ADDR_BITS-1:8], w_rdAddr[1:0]};

    // A start write is applied after finish so it wins when both land together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_ecnt      <= '0;
            r_insnCount <= '0;
        end else begin
            if (finish) begin
                r_start <= 1'b0;
                r_done  <= 1'b1;
            end
            if (w_startWrite) begin
                r_start <= 1'b1;
                r_done  <= 1'b0;
            end
            if (w_wrEn && w_wrWord == WORD_ECNT)
                r_ecnt <= applyStrobe(r_ecnt, w_wrData, w_wrStrb);
            else if (r_start && !finish)
                r_ecnt <= r_ecnt + 32'd1;
            if (w_wrEn && w_wrWord == WORD_INSN_COUNT)
                r_insnCount <= applyStrobe(r_insnCount, w_wrData, w_wrStrb);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (!reset_n)
                r_ptr[i] <= '0;
            else if (w_wrEn && w_wrWord == 6'(WORD_PTR_INSN + i))
                r_ptr[i] <= applyStrobe(r_ptr[i], w_wrData, w_wrStrb);
        end
    end

    always_comb begin
        w_rdData = '0;
        if (w_rdEn) begin
            case (w_rdWord)
                WORD_CTRL: begin
                    w_rdData[CTRL_START] = r_start;
                    w_rdData[CTRL_DONE]  = r_done;
                end
                WORD_ECNT:       w_rdData = r_ecnt;
                WORD_INSN_COUNT: w_rdData = r_insnCount;
                WORD_PTR_INSN:   w_rdData = r_ptr[0];
                WORD_PTR_UOP:    w_rdData = r_ptr[1];
                WORD_PTR_INP:    w_rdData = r_ptr[2];
                WORD_PTR_WGT:    w_rdData = r_ptr[3];
                WORD_PTR_ACC:    w_rdData = r_ptr[4];
                WORD_PTR_OUT:    w_rdData = r_ptr[5];
                default:         w_rdData = '0;
            endcase
        end
    end

    assign launch     = r_start;
    assign insn_count = r_insnCount;
    assign ptr_insn   = r_ptr[0];
    assign ptr_uop    = r_ptr[1];
    assign ptr_inp    = r_ptr[2];
    assign ptr_wgt    = r_ptr[3];
    assign ptr_acc    = r_ptr[4];
    assign ptr_out    = r_ptr[5];

endmodule

// File: tb/tb_vta_sys_wrapper.sv
// Directed and randomized checks of the VTA register block against a
// word-array model of the register map.
module tb_vta_sys_wrapper;

    logic        clock;
    logic        reset_n;
    logic        s_awvalid, s_awready;
    logic [15:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [15:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        launch, finish;
    logic [31:0] insn_count, ptr_insn, ptr_uop, ptr_inp, ptr_wgt, ptr_acc, ptr_out;

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle = 0;
    int unsigned commitCycle = 0;
    int          bCount = 0;
    logic [31:0] model [0:63];
    logic [31:0] rd;

    vta_sys_wrapper dut (
        .clock(clock), .reset_n(reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .launch(launch), .finish(finish), .insn_count(insn_count),
        .ptr_insn(ptr_insn), .ptr_uop(ptr_uop), .ptr_inp(ptr_inp),
        .ptr_wgt(ptr_wgt), .ptr_acc(ptr_acc), .ptr_out(ptr_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;
    always @(posedge clock) if (s_bvalid && s_bready) bCount <= bCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                               input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    function automatic logic [31:0] portFor(input int word);
        case (word)
            2: return insn_count;
            3: return ptr_insn;
            4: return ptr_uop;
            5: return ptr_inp;
            6: return ptr_wgt;
            7: return ptr_acc;
            8: return ptr_out;
            default: return 32'h0;
        endcase
    endfunction

    task automatic axiWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay, input int bDelay);
        int n;
        fork
            begin
                int na;
                repeat (awDelay) @(negedge clock);
                s_awaddr = addr; s_awvalid = 1'b1;
                na = 0;
                while (s_awready !== 1'b1 && na < 50) begin @(negedge clock); na++; end
                checkOutput("aw_accept", {31'b0, s_awready}, 32'h1);
                @(negedge clock); s_awvalid = 1'b0;
            end
            begin
                int nw;
                repeat (wDelay) @(negedge clock);
                s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
                nw = 0;
                while (s_wready !== 1'b1 && nw < 50) begin @(negedge clock); nw++; end
                checkOutput("w_accept", {31'b0, s_wready}, 32'h1);
                @(negedge clock); s_wvalid = 1'b0;
            end
        join
        n = 0;
        while (s_bvalid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        commitCycle = cycle;
        repeat (bDelay) @(negedge clock);
        checkOutput("bvalid_held", {31'b0, s_bvalid}, 32'h1);
        checkOutput("bresp", {30'b0, s_bresp}, 32'h0);
        s_bready = 1'b1;
        @(negedge clock); s_bready = 1'b0;
        checkOutput("bvalid_drop", {31'b0, s_bvalid}, 32'h0);
        checkOutput("readies_back", {30'b0, s_awready, s_wready}, 32'h3);
    endtask

    task automatic axiRead(input logic [15:0] addr, input int rDelay, output logic [31:0] data);
        int n;
        s_araddr = addr; s_arvalid = 1'b1;
        n = 0;
        while (s_arready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        checkOutput("ar_accept", {31'b0, s_arready}, 32'h1);
        @(negedge clock); s_arvalid = 1'b0;
        checkOutput("rvalid_next", {30'b0, s_rvalid, s_arready}, 32'h2);
        data = s_rdata;
        repeat (rDelay) @(negedge clock);
        checkOutput("rresp", {30'b0, s_rresp}, 32'h0);
        s_rready = 1'b1;
        @(negedge clock); s_rready = 1'b0;
        checkOutput("arready_back", {30'b0, s_rvalid, s_arready}, 32'h1);
    endtask

    task automatic pulseFinish();
        finish = 1'b1;
        @(negedge clock); finish = 1'b0;
    endtask

    initial begin
        int bBefore;
        int word;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;

        reset_n = 1'b0; finish = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;

        $display("[TB] reset");
        repeat (100) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("reset_readies", {29'b0, s_awready, s_wready, s_arready}, 32'h7);
        checkOutput("reset_valids", {30'b0, s_bvalid, s_rvalid}, 32'h0);
        checkOutput("reset_launch", {31'b0, launch}, 32'h0);
        for (int w = 0; w <= 8; w++) begin
            axiRead(16'(w * 4), 0, rd);
            checkOutput("reset_read", rd, 32'h0);
            checkOutput("reset_port", portFor(w), 32'h0);
        end

        $display("[TB] register readback");
        axiWrite(16'h0008, 32'd7, 4'hF, 0, 0, 0);
        axiRead(16'h0008, 1, rd);
        checkOutput("insn_read", rd, 32'd7);
        checkOutput("insn_port", insn_count, 32'd7);
        axiWrite(16'h000C, 32'hFFFC_0000, 4'hF, 1, 0, 1);
        axiRead(16'h000C, 0, rd);
        checkOutput("ptr_insn_read", rd, 32'hFFFC_0000);
        checkOutput("ptr_insn_port", ptr_insn, 32'hFFFC_0000);
        for (int w = 4; w <= 8; w++) begin
            axiWrite(16'(w * 4), 32'h0, 4'hF, 0, 1, 0);
            axiRead(16'(w * 4), 0, rd);
            checkOutput("ptr_zero_read", rd, 32'h0);
        end

        $display("[TB] run");
        axiWrite(16'h0004, 32'h0, 4'hF, 0, 0, 0);
        axiWrite(16'h0000, 32'h1, 4'hF, 0, 0, 0);
        checkOutput("launch_high", {31'b0, launch}, 32'h1);
        while (cycle < commitCycle + 50) @(negedge clock);
        pulseFinish();
        checkOutput("launch_low", {31'b0, launch}, 32'h0);
        axiRead(16'h0000, 0, rd);
        checkOutput("ctrl_done", rd, 32'h2);
        axiRead(16'h0004, 0, rd);
        checkOutput("ecnt_50", rd, 32'd50);

        $display("[TB] restart");
        axiWrite(16'h0000, 32'h1, 4'hF, 0, 0, 0);
        axiRead(16'h0000, 0, rd);
        checkOutput("ctrl_restart", rd, 32'h1);
        pulseFinish();
        axiRead(16'h0000, 0, rd);
        checkOutput("ctrl_done_again", rd, 32'h2);

        $display("[TB] handshake ordering");
        bBefore = bCount;
        data = $urandom;
        axiWrite(16'h0018, data, 4'hF, 2, 0, 5);
        @(negedge clock);
        checkOutput("single_bresp", 32'(bCount - bBefore), 32'h1);
        axiRead(16'h0018, 2, rd);
        checkOutput("ordered_commit", rd, data);
        axiRead(16'h0024, 0, rd);
        checkOutput("unmapped_read", rd, 32'h0);

        $display("[TB] strobes");
        axiWrite(16'h0014, 32'hAABB_CCDD, 4'b0011, 0, 0, 0);
        axiRead(16'h0014, 0, rd);
        checkOutput("strobe_read", rd, 32'h0000_CCDD);

        $display("[TB] reset mid-transaction");
        s_awaddr = 16'h0008; s_awvalid = 1'b1;
        s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clock);
        s_awvalid = 1'b0; s_wvalid = 1'b0; reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("abort_bvalid", {31'b0, s_bvalid}, 32'h0);
        checkOutput("abort_readies", {30'b0, s_awready, s_wready}, 32'h3);
        checkOutput("abort_insn", insn_count, 32'h0);
        checkOutput("abort_ptr_wgt", ptr_wgt, 32'h0);

        $display("[TB] random traffic");
        for (int k = 0; k < 40; k++) begin
            word = ($urandom_range(0, 3) != 0) ? int'($urandom_range(2, 8)) : int'($urandom_range(9, 63));
            addr = {8'h00, word[5:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axiWrite(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
                if (word <= 8) begin
                    model[word] = mergeBytes(model[word], data, strb);
                    checkOutput("rand_port", portFor(word), model[word]);
                end
            end else begin
                axiRead(addr, $urandom_range(0, 2), rd);
                checkOutput("rand_read", rd, (word <= 8) ? model[word] : 32'h0);
            end
        end
        for (int w = 2; w <= 8; w++) begin
            axiRead(16'(w * 4), 0, rd);
            checkOutput("final_read", rd, model[w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
